// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin codes, coin values and the
// change-dispense sequencer state encoding.
package vending_pkg;

    // Coin codes match the control unit's IN_PRICE_MONEY encoding
    localparam logic [1:0] COIN_50   = 2'd0;
    localparam logic [1:0] COIN_100  = 2'd1;
    localparam logic [1:0] COIN_500  = 2'd2;
    localparam logic [1:0] COIN_1000 = 2'd3;

    localparam int unsigned VALUE_50   = 50;
    localparam int unsigned VALUE_100  = 100;
    localparam int unsigned VALUE_500  = 500;
    localparam int unsigned VALUE_1000 = 1000;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_SELECT,
        SEQ_ISSUE,
        SEQ_FINISH
    } seq_state_t;

    function automatic int unsigned coin_value(input logic [1:0] code);
        int unsigned value;
        case (code)
            COIN_50:   value = VALUE_50;
            COIN_100:  value = VALUE_100;
            COIN_500:  value = VALUE_500;
            default:   value = VALUE_1000;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational greedy pick: the largest coin that fits the remaining amount
// and is still stocked in its tube.
module coin_select
    import vending_pkg::*;
#(
    parameter int MONEY_W = 16,
    parameter int CNT_W   = 8
)
(
    input  logic [MONEY_W-1:0]  remaining,
    input  logic [4*CNT_W-1:0]  tube_cnt,
    output logic                found,
    output logic [1:0]          code,
    output logic [MONEY_W-1:0]  value
);

    // Coin codes are ordered by value, so scanning from the top code down
    // yields the priority 1000, 500, 100, 50.
    always_comb begin
        found = 1'b0;
        code  = COIN_50;
        for (int i = 3; i >= 0; i--) begin
            if (!found && (tube_cnt[i*CNT_W +: CNT_W] != '0) &&
                (remaining >= MONEY_W'(coin_value(2'(i))))) begin
                found = 1'b1;
                code  = 2'(i);
            end
        end
        value = found ? MONEY_W'(coin_value(code)) : '0;
    end

endmodule

// File: rtl/change_dispense_sequencer.sv
// Inventory-aware change return: greedily ejects coins one handshake at a time.
// Optional dispenser ACK timeout is enabled with `define CHANGE_TIMEOUT_EN.
module change_dispense_sequencer
    import vending_pkg::*;
#(
    parameter int MONEY_W     = 16,
    parameter int CNT_W       = 8
`ifdef CHANGE_TIMEOUT_EN
    ,
    parameter int ACK_TIMEOUT = 255
`endif
)
(
    input  logic                CLK,
    input  logic                RST,
    input  logic                START_RETURN,
    input  logic [MONEY_W-1:0]  AMOUNT,
    input  logic                LOAD,
    input  logic [1:0]          LOAD_COIN,
    input  logic [CNT_W-1:0]    LOAD_CNT,
    output logic                EJECT_REQ,
    output logic [1:0]          EJECT_COIN,
    input  logic                EJECT_ACK,
    output logic                BUSY,
    output logic                DONE,
    output logic [MONEY_W-1:0]  SHORTFALL,
    output logic                FAULT,
    output logic [4*CNT_W-1:0]  TUBE_CNT
);

    seq_state_t          state;
    seq_state_t          state_next;
    logic [MONEY_W-1:0]  remaining;
    logic [MONEY_W-1:0]  coin_val_q;
    logic [1:0]          eject_coin;
    logic [MONEY_W-1:0]  shortfall;
    logic [CNT_W-1:0]    tube [4];
    logic [4*CNT_W-1:0]  tube_packed;
    logic [CNT_W:0]      load_sum;
    logic [CNT_W-1:0]    load_sat;
    logic                sel_found;
    logic [1:0]          sel_code;
    logic [MONEY_W-1:0]  sel_value;
    logic                timeout_hit;

    assign tube_packed = {tube[3], tube[2], tube[1], tube[0]};
    assign TUBE_CNT    = tube_packed;
    assign EJECT_COIN  = eject_coin;
    assign SHORTFALL   = shortfall;
    assign EJECT_REQ   = (state == SEQ_ISSUE);
    assign BUSY        = (state != SEQ_IDLE);
    assign DONE        = (state == SEQ_FINISH);

    // Refills saturate so an over-full tube never wraps to a small count
    assign load_sum = {1'b0, tube[LOAD_COIN]} + {1'b0, LOAD_CNT};
    assign load_sat = load_sum[CNT_W] ? {CNT_W{1'b1}} : load_sum[CNT_W-1:0];

    coin_select #(
        .MONEY_W (MONEY_W),
        .CNT_W   (CNT_W)
    ) u_coin_select (
        .remaining (remaining),
        .tube_cnt  (tube_packed),
        .found     (sel_found),
        .code      (sel_code),
        .value     (sel_value)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SEQ_IDLE: begin
                if (START_RETURN) begin
                    state_next = SEQ_SELECT;
                end
            end
            SEQ_SELECT: begin
                state_next = sel_found ? SEQ_ISSUE : SEQ_FINISH;
            end
            SEQ_ISSUE: begin
                if (EJECT_ACK) begin
                    state_next = SEQ_SELECT;
                end else if (timeout_hit) begin
                    state_next = SEQ_FINISH;
                end
            end
            SEQ_FINISH: begin
                state_next = SEQ_IDLE;
            end
            default: begin
                state_next = SEQ_IDLE;
            end
        endcase
    end

    // Selection guarantees the latched coin value never exceeds remaining,
    // so the subtraction on ACK cannot underflow.
    always_ff @(posedge CLK) begin
        if (RST) begin
            remaining  <= '0;
            coin_val_q <= '0;
            eject_coin <= COIN_50;
            shortfall  <= '0;
            for (int i = 0; i < 4; i++) begin
                tube[i] <= '0;
            end
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (START_RETURN) begin
                        remaining <= AMOUNT;
                        shortfall <= '0;
                    end else if (LOAD) begin
                        tube[LOAD_COIN] <= load_sat;
                    end
                end
                SEQ_SELECT: begin
                    if (sel_found) begin
                        eject_coin <= sel_code;
                        coin_val_q <= sel_value;
                    end else begin
                        shortfall <= remaining;
                    end
                end
                SEQ_ISSUE: begin
                    if (EJECT_ACK) begin
                        tube[eject_coin] <= tube[eject_coin] - 1'b1;
                        remaining        <= remaining - coin_val_q;
                    end else if (timeout_hit) begin
                        shortfall <= remaining;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CHANGE_TIMEOUT_EN
    localparam int TIMER_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    logic [TIMER_W-1:0] ack_timer;
    logic               fault_q;

    assign timeout_hit = (ack_timer == TIMER_W'(ACK_TIMEOUT - 1));
    assign FAULT       = fault_q;

    // The timer counts ISSUE cycles; the abandoned coin stays in its tube
    always_ff @(posedge CLK) begin
        if (RST) begin
            ack_timer <= '0;
            fault_q   <= 1'b0;
        end else begin
            if (state == SEQ_ISSUE && !EJECT_ACK) begin
                ack_timer <= ack_timer + 1'b1;
            end else begin
                ack_timer <= '0;
            end
            if (state == SEQ_IDLE && START_RETURN) begin
                fault_q <= 1'b0;
            end else if (state == SEQ_ISSUE && !EJECT_ACK && timeout_hit) begin
                fault_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign FAULT       = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispense_sequencer.sv
// Scoreboard bench for change_dispense_sequencer: a greedy reference model
// predicts ejects and DONE records; a monitor process checks them.
`timescale 1ns/1ps
module tb_change_dispense_sequencer;

    localparam int MONEY_W = 16;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int COIN_VAL [4] = '{50, 100, 500, 1000};

    typedef struct {
        int                  shortfall;
        bit                  fault;
        logic [4*CNT_W-1:0]  tubes;
    } done_rec_t;

    logic                CLK = 1'b0;
    logic                RST;
    logic                START_RETURN;
    logic [MONEY_W-1:0]  AMOUNT;
    logic                LOAD;
    logic [1:0]          LOAD_COIN;
    logic [CNT_W-1:0]    LOAD_CNT;
    logic                EJECT_REQ;
    logic [1:0]          EJECT_COIN;
    logic                EJECT_ACK;
    logic                BUSY;
    logic                DONE;
    logic [MONEY_W-1:0]  SHORTFALL;
    logic                FAULT;
    logic [4*CNT_W-1:0]  TUBE_CNT;

    logic [1:0]  exp_coin_q [$];
    done_rec_t   exp_done_q [$];
    int          model_tube [4];
    int          checks = 0;
    int          failures = 0;
    int          done_seen = 0;
    int          req_cycles = 0;
    bit          ack_enable = 1'b1;
    bit          noise_en = 1'b0;
    int          fixed_delay = -1;

    always #5 CLK = ~CLK;

    change_dispense_sequencer #(
        .MONEY_W (MONEY_W),
        .CNT_W   (CNT_W)
`ifdef CHANGE_TIMEOUT_EN
        ,
        .ACK_TIMEOUT (4)
`endif
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .START_RETURN (START_RETURN),
        .AMOUNT       (AMOUNT),
        .LOAD         (LOAD),
        .LOAD_COIN    (LOAD_COIN),
        .LOAD_CNT     (LOAD_CNT),
        .EJECT_REQ    (EJECT_REQ),
        .EJECT_COIN   (EJECT_COIN),
        .EJECT_ACK    (EJECT_ACK),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .SHORTFALL    (SHORTFALL),
        .FAULT        (FAULT),
        .TUBE_CNT     (TUBE_CNT)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic failEvent(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: event occurred that the model does not allow", name);
    endtask

    function automatic logic [4*CNT_W-1:0] packTubes();
        logic [4*CNT_W-1:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i*CNT_W +: CNT_W] = CNT_W'(model_tube[i]);
        end
        return p;
    endfunction

    // Single-cycle input drive; called and returns on a falling edge
    task automatic applyStimulus(input bit start, input int amount, input bit load, input int coin, input int cnt);
        START_RETURN = start;
        AMOUNT       = MONEY_W'(amount);
        LOAD         = load;
        LOAD_COIN    = 2'(coin);
        LOAD_CNT     = CNT_W'(cnt);
        @(negedge CLK);
        START_RETURN = 1'b0;
        LOAD         = 1'b0;
    endtask

    task automatic doReset();
        RST = 1'b1;
        exp_coin_q.delete();
        exp_done_q.delete();
        for (int i = 0; i < 4; i++) model_tube[i] = 0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic doLoad(input int coin, input int cnt);
        model_tube[coin] = (model_tube[coin] + cnt > CNT_MAX) ? CNT_MAX : model_tube[coin] + cnt;
        applyStimulus(1'b0, 0, 1'b1, coin, cnt);
    endtask

    // Reference model: repeatedly take the most valuable stocked coin that fits
    task automatic doReturn(input int amount, input bit poke, input bit with_load, input int lcoin, input int lcnt);
        int        rem;
        int        sel;
        int        done_before;
        int        cyc;
        bit        fault;
        bit        first_found;
        done_rec_t rec;
        rem = amount;
        fault = 1'b0;
        first_found = 1'b0;
        forever begin
            sel = -1;
            for (int i = 3; i >= 0; i--) begin
                if (sel < 0 && model_tube[i] > 0 && COIN_VAL[i] <= rem) sel = i;
            end
            if (sel < 0) break;
            first_found = 1'b1;
            if (!ack_enable) begin
                fault = 1'b1;
                break;
            end
            exp_coin_q.push_back(2'(sel));
            model_tube[sel]--;
            rem -= COIN_VAL[sel];
        end
        rec.shortfall = rem;
        rec.fault     = fault;
        rec.tubes     = packTubes();
        exp_done_q.push_back(rec);
        done_before = done_seen;

        applyStimulus(1'b1, amount, with_load, lcoin, lcnt);
        checkOutput("start_busy", 64'(BUSY), 64'(1));
        checkOutput("select_no_req", 64'(EJECT_REQ), 64'(0));
        if (poke) begin
            START_RETURN = 1'b1;
            AMOUNT       = MONEY_W'($urandom_range(0, 3000));
            LOAD         = 1'b1;
            LOAD_COIN    = 2'($urandom_range(0, 3));
            LOAD_CNT     = CNT_W'($urandom_range(1, 9));
        end
        @(negedge CLK);
        START_RETURN = 1'b0;
        LOAD         = 1'b0;
        if (first_found) checkOutput("start_to_req", 64'(EJECT_REQ), 64'(1));
        else             checkOutput("start_to_done", 64'(DONE), 64'(1));

        cyc = 0;
        while (done_seen == done_before && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
        end
        if (done_seen == done_before) failEvent("done_timeout");
    endtask

    // Dispenser: acknowledges each request after a delay; optional ACK noise while idle
    initial begin
        int wait_left;
        wait_left = -1;
        EJECT_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (!EJECT_REQ || !ack_enable) begin
                EJECT_ACK = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                wait_left = -1;
            end else begin
                if (wait_left < 0) wait_left = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                if (wait_left == 0) begin
                    EJECT_ACK = 1'b1;
                end else begin
                    EJECT_ACK = 1'b0;
                    wait_left--;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an accepted eject or DONE
    initial begin
        bit        prev_req;
        bit        prev_done;
        logic [1:0] prev_coin;
        done_rec_t rec;
        prev_req = 1'b0;
        prev_done = 1'b0;
        prev_coin = '0;
        forever begin
            @(negedge CLK);
            #1;
            if (RST) begin
                prev_req = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (EJECT_REQ) req_cycles++;
                if (prev_req && EJECT_REQ) checkOutput("coin_stable", 64'(EJECT_COIN), 64'(prev_coin));
                if (EJECT_REQ && EJECT_ACK) begin
                    if (exp_coin_q.size() == 0) failEvent("unexpected_eject");
                    else checkOutput("eject_coin", 64'(EJECT_COIN), 64'(exp_coin_q.pop_front()));
                end
                if (DONE) begin
                    if (prev_done) failEvent("done_longer_than_one_cycle");
                    if (exp_done_q.size() == 0) begin
                        failEvent("unexpected_done");
                    end else begin
                        rec = exp_done_q.pop_front();
                        checkOutput("shortfall", 64'(SHORTFALL), 64'(rec.shortfall));
                        checkOutput("fault", 64'(FAULT), 64'(rec.fault));
                        checkOutput("tubes", 64'(TUBE_CNT), 64'(rec.tubes));
                        if (exp_coin_q.size() != 0) failEvent("done_with_ejects_pending");
                    end
                    done_seen++;
                end
                prev_req  = EJECT_REQ;
                prev_done = DONE;
                prev_coin = EJECT_COIN;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: actual=expired required=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int req_before;
        int amt;
        RST = 1'b1;
        START_RETURN = 1'b0;
        AMOUNT = '0;
        LOAD = 1'b0;
        LOAD_COIN = '0;
        LOAD_CNT = '0;
        @(negedge CLK);
        doReset();

        $display("[TB] reset state");
        checkOutput("rst_req", 64'(EJECT_REQ), 64'(0));
        checkOutput("rst_coin", 64'(EJECT_COIN), 64'(0));
        checkOutput("rst_busy", 64'(BUSY), 64'(0));
        checkOutput("rst_done", 64'(DONE), 64'(0));
        checkOutput("rst_shortfall", 64'(SHORTFALL), 64'(0));
        checkOutput("rst_fault", 64'(FAULT), 64'(0));
        checkOutput("rst_tubes", 64'(TUBE_CNT), 64'(0));

        $display("[TB] refill saturation");
        doLoad(0, 200);
        doLoad(0, 100);
        checkOutput("tube_saturate", 64'(TUBE_CNT), 64'(packTubes()));

        $display("[TB] full greedy return 1650");
        doReset();
        doLoad(3, 2); doLoad(2, 2); doLoad(1, 5); doLoad(0, 5);
        doReturn(1650, 1'b0, 1'b0, 0, 0);

        $display("[TB] 1000 from 500s only");
        doReset();
        doLoad(2, 3);
        doReturn(1000, 1'b0, 1'b0, 0, 0);

        $display("[TB] 380 with a single 100");
        doReset();
        doLoad(1, 1);
        doReturn(380, 1'b0, 1'b0, 0, 0);

        $display("[TB] zero return");
        doReturn(0, 1'b0, 1'b0, 0, 0);

        $display("[TB] dispenser holds ACK low");
        doReset();
        doLoad(1, 1);
        fixed_delay = 5;
        req_before = req_cycles;
        doReturn(100, 1'b0, 1'b0, 0, 0);
        checkOutput("req_hold_cycles", 64'(req_cycles - req_before), 64'(6));
        fixed_delay = -1;

        $display("[TB] START and LOAD together");
        doReset();
        doLoad(2, 1);
        doReturn(500, 1'b0, 1'b1, 2, 7);

        $display("[TB] reset during ISSUE");
        doReset();
        doLoad(2, 1);
        ack_enable = 1'b0;
        applyStimulus(1'b1, 500, 1'b0, 0, 0);
        @(negedge CLK);
        checkOutput("issue_req", 64'(EJECT_REQ), 64'(1));
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("abort_busy", 64'(BUSY), 64'(0));
        checkOutput("abort_req", 64'(EJECT_REQ), 64'(0));
        checkOutput("abort_done", 64'(DONE), 64'(0));
        checkOutput("abort_tubes", 64'(TUBE_CNT), 64'(0));
        RST = 1'b0;
        for (int i = 0; i < 4; i++) model_tube[i] = 0;
        ack_enable = 1'b1;
        repeat (6) @(negedge CLK);

`ifdef CHANGE_TIMEOUT_EN
        $display("[TB] dispenser timeout");
        doReset();
        doLoad(1, 1);
        ack_enable = 1'b0;
        req_before = req_cycles;
        doReturn(100, 1'b0, 1'b0, 0, 0);
        checkOutput("timeout_req_cycles", 64'(req_cycles - req_before), 64'(4));
        repeat (3) @(negedge CLK);
        checkOutput("fault_hold", 64'(FAULT), 64'(1));
        ack_enable = 1'b1;
        doReturn(0, 1'b0, 1'b0, 0, 0);
`endif

        $display("[TB] randomized returns");
        doReset();
        noise_en = 1'b1;
        for (int n = 0; n < 25; n++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 1) == 1) doLoad(c, int'($urandom_range(1, 6)));
            end
            amt = int'($urandom_range(0, 60)) * 50;
            if ($urandom_range(0, 3) == 0) amt += int'($urandom_range(1, 49));
            doReturn(amt, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                     int'($urandom_range(0, 3)), int'($urandom_range(1, 9)));
        end
        noise_en = 1'b0;
        repeat (4) @(negedge CLK);
        checkOutput("final_tubes", 64'(TUBE_CNT), 64'(packTubes()));
        checkOutput("final_idle", 64'(BUSY), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/change_dispense_sequencer.md
Name: change_dispense_sequencer

Overview:
- Schedules coin ejection for the change-return phase of the vending machine.
- The control unit raises START_RETURN with the residual credit. This block greedily picks denominations against its own coin-tube inventory and drives the coin dispenser one coin per handshake.
- It reports DONE along with any amount it could not pay out.
- It sits between the control unit's money-return states and the physical dispenser, and it replaces fixed-denomination return with an inventory-aware return.

Parameters:
- MONEY_W, 16, width of amount and remaining registers.
- CNT_W, 8, width of each coin-tube counter; saturates at 2^CNT_W-1.
- ACK_TIMEOUT, 255, cycles to wait for EJECT_ACK. Used only with CHANGE_TIMEOUT_EN.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous active-high reset.
- START_RETURN  in  1  one-cycle pulse that begins a return; sampled only in IDLE.
- AMOUNT  in  MONEY_W  credit to return; captured with START_RETURN.
- LOAD  in  1  refill strobe; honoured only in IDLE.
- LOAD_COIN  in  2  coin code for the refill: 0=50, 1=100, 2=500, 3=1000.
- LOAD_CNT  in  CNT_W  number of coins added to the tube.
- EJECT_REQ  out  1  request to the dispenser to eject one coin.
- EJECT_COIN  out  2  coin code; stable while EJECT_REQ is high.
- EJECT_ACK  in  1  dispenser accepted the coin; meaningful only while EJECT_REQ=1.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when a return finishes.
- SHORTFALL  out  MONEY_W  unpaid remainder; valid from DONE until the next START_RETURN.
- FAULT  out  1  dispenser timeout flag; tied 0 without the macro.
- TUBE_CNT  out  4*CNT_W  tube counts packed {1000,500,100,50}.

Behaviour:
- Reset (RST=1 at posedge): state=IDLE; EJECT_REQ=0, EJECT_COIN=0, BUSY=0, DONE=0, SHORTFALL=0, FAULT=0; all tube counts 0; remaining=0.
  - Reset mid-operation aborts immediately. No DONE is produced, and the coin in flight is not decremented.
- States: IDLE, SELECT, ISSUE, FINISH.
- IDLE:
  - On START_RETURN, capture AMOUNT into remaining and go to SELECT. SHORTFALL and FAULT clear at this point.
  - Otherwise, if LOAD, tube[LOAD_COIN] += LOAD_CNT, saturating at max.
  - If START_RETURN and LOAD arrive in the same cycle, START wins and LOAD is dropped.
- SELECT:
  - Choose the largest coin value v <= remaining with tube count > 0, in priority order 1000, 500, 100, 50.
  - If a coin is found: latch EJECT_COIN and go to ISSUE.
  - If remaining==0, or no eligible coin exists: SHORTFALL<=remaining, go to FINISH.
- ISSUE:
  - EJECT_REQ=1 and held until EJECT_ACK is sampled high; EJECT_COIN does not change while held.
  - On the ACK cycle: tube[EJECT_COIN] -= 1, remaining -= value, EJECT_REQ drops at the next edge, go to SELECT.
  - An ACK that arrives while EJECT_REQ=0 is ignored.
- FINISH: DONE=1 for exactly one cycle, then IDLE.
- Latency:
  - START_RETURN → EJECT_REQ high: 2 cycles.
  - ACK → next EJECT_REQ: 2 cycles.
  - A return of 0 gives DONE 2 cycles after START.
- START_RETURN and LOAD are ignored while BUSY.
- Amounts that are not multiples of 50 leave the residue (<50) in SHORTFALL.
- Arithmetic: remaining never underflows, because selection guarantees v <= remaining. Coin values are constants zero-extended to MONEY_W.
- Inventory exhaustion: greedy falls back to smaller coins. Example: 1000 with no 1000 coins pays 2×500.

Optional Feature:
- Macro: CHANGE_TIMEOUT_EN.
- Defined:
  - A counter runs while in ISSUE.
  - After ACK_TIMEOUT cycles with no ACK: EJECT_REQ drops, FAULT=1, SHORTFALL<=remaining, go to FINISH. The coin is not decremented.
  - FAULT holds until the next START_RETURN or RST.
- Undefined: ISSUE waits indefinitely; FAULT is constant 0 and no counter is synthesised.

Decomposition:
- Shared package vending_pkg holds:
  - coin code constants COIN_50/100/500/1000 (0..3), identical to the control unit's IN_PRICE_MONEY encoding;
  - coin value constants 50/100/500/1000;
  - the sequencer state encoding.
- One sub-module is natural: coin_select. It is combinational and takes remaining plus the four tube counts. It outputs found, code and value, using a priority pick.

Test Plan:
- Refill 2×1000, 2×500, 5×100, 5×50 in IDLE; START 1650 → ejects 1000, 500, 100, 50; DONE; SHORTFALL=0; tubes {1,1,4,4}.
- Tubes {0,3,0,0}; START 1000 → two 500 ejects; DONE; SHORTFALL=0; tube500=1.
- Tubes {0,0,1,0}; START 380 → one 100 eject; SHORTFALL=280.
- Dispenser holds ACK low 5 cycles → EJECT_REQ and EJECT_COIN stable for 5 cycles; exactly one decrement after ACK.
- START 500 and LOAD in the same IDLE cycle → return proceeds, tube unchanged by LOAD. Assert RST during ISSUE → next cycle IDLE, REQ=0, no DONE, counts=0.
- With CHANGE_TIMEOUT_EN, ACK_TIMEOUT=4, ACK never asserted, START 100 (tube100=1) → FAULT=1, SHORTFALL=100, tube100 still 1, DONE pulses.
